// File: rtl/rr_encoder_8_to_3.sv
// rtl/rr_encoder_8_to_3.sv - round-robin 8-to-3 encoder with pending capture and valid/ready output
// Optional macro RR_ENCODER_FIXED_PRIORITY_EN: lowest pending line always wins, no rotation pointer.
module rr_encoder_8_to_3 #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         out_ready,
  input  logic         clr_ovf,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t       state, state_n;
  logic [W-1:0] sel;
  logic [W-1:0] idx_n;
  logic [N-1:0] onehot_n;
  logic [N-1:0] clear_mask;
  logic [N-1:0] pending_n;
  logic         overflow_n;
  logic         free;

`ifndef RR_ENCODER_FIXED_PRIORITY_EN
  logic [W-1:0] ptr, ptr_n;
  logic [W-1:0] cand;
`endif

  assign out_valid = (state == HOLD);
  assign free      = (state == IDLE) || out_ready;

  // Descending scan so the candidate closest to the start point is assigned last and wins.
  always_comb begin
    sel = '0;
`ifdef RR_ENCODER_FIXED_PRIORITY_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) sel = W'(i);
    end
`else
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + W'(i);
      if (pending[cand]) sel = cand;
    end
`endif
  end

  always_comb begin
    state_n    = state;
    idx_n      = out_idx;
    onehot_n   = out_onehot;
    clear_mask = '0;
`ifndef RR_ENCODER_FIXED_PRIORITY_EN
    ptr_n      = ptr;
`endif
    if (free) begin
      if (|pending) begin
        state_n    = HOLD;
        idx_n      = sel;
        onehot_n   = {{(N-1){1'b0}}, 1'b1} << sel;
        clear_mask = onehot_n;
`ifndef RR_ENCODER_FIXED_PRIORITY_EN
        ptr_n      = sel + W'(1);
`endif
      end else begin
        state_n  = IDLE;
        onehot_n = '0;
      end
    end
    pending_n  = (pending & ~clear_mask) | req_i;
    // A request landing on a still-pending line that is not being granted is merged and lost.
    overflow_n = (|(req_i & pending & ~clear_mask)) | (overflow & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_idx    <= '0;
      out_onehot <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
`ifndef RR_ENCODER_FIXED_PRIORITY_EN
      ptr        <= '0;
`endif
    end else begin
      state      <= state_n;
      out_idx    <= idx_n;
      out_onehot <= onehot_n;
      pending    <= pending_n;
      overflow   <= overflow_n;
`ifndef RR_ENCODER_FIXED_PRIORITY_EN
      ptr        <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_rr_encoder_8_to_3.sv
// tb/tb_rr_encoder_8_to_3.sv - scoreboard bench for rr_encoder_8_to_3
module tb_rr_encoder_8_to_3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_i;
  logic       out_ready;
  logic       clr_ovf;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic [7:0] pending;
  logic       overflow;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] oh;
  } grant_t;

  grant_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  rr_encoder_8_to_3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .out_ready  (out_ready),
    .clr_ovf    (clr_ovf),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [2:0] idx);
    grant_t g;
    g.idx = idx;
    g.oh  = 8'h01 << idx;
    sb.push_back(g);
  endtask

  // Monitor: every accepted transfer is matched against the next expected grant.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_grant: got idx %0d expected none at %0t", out_idx, $time);
      end else begin
        grant_t e;
        e = sb.pop_front();
        chk("grant_idx", 32'(out_idx), 32'(e.idx));
        chk("grant_onehot", 32'(out_onehot), 32'(e.oh));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_i = 8'hFF; out_ready = 1'b0; clr_ovf = 1'b0;

    // Test 1: reset with all requests asserted
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_onehot", 32'(out_onehot), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    req_i = 8'h00;
    tick(); rst_n = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_pending", 32'(pending), 0);

    // Test 2: two simultaneous requests drain in order
    tick();
    expect_grant(3'd0); expect_grant(3'd3);
    out_ready = 1'b1; req_i = 8'h09;
    tick(); req_i = 8'h00;
    repeat (4) tick();
    @(negedge clk);
    chk("t2_valid", 32'(out_valid), 0);
    chk("t2_pending", 32'(pending), 0);
    chk("t2_overflow", 32'(overflow), 0);

    // Test 3: stall, re-arm line 0, then drain
    tick();
`ifdef RR_ENCODER_FIXED_PRIORITY_EN
    expect_grant(3'd0); expect_grant(3'd0); expect_grant(3'd1);
`else
    expect_grant(3'd0); expect_grant(3'd1); expect_grant(3'd0);
`endif
    out_ready = 1'b0; req_i = 8'h03;
    tick(); req_i = 8'h00;
    tick();
    @(negedge clk);
    chk("t3_hold_valid", 32'(out_valid), 1);
    chk("t3_hold_idx", 32'(out_idx), 0);
    chk("t3_pending_a", 32'(pending), 32'h02);
    req_i = 8'h01;
    tick(); req_i = 8'h00;
    @(negedge clk);
    chk("t3_pending_b", 32'(pending), 32'h03);
    chk("t3_overflow", 32'(overflow), 0);
    chk("t3_idx_stable", 32'(out_idx), 0);
    tick(); out_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("t3_idle", 32'(out_valid), 0);
    chk("t3_pending_end", 32'(pending), 0);

    // Test 4: duplicate request sets overflow, clr_ovf clears it
    tick();
    expect_grant(3'd2); expect_grant(3'd4);
    out_ready = 1'b0; req_i = 8'h04;
    tick(); req_i = 8'h00;
    tick(); req_i = 8'h10;
    tick(); req_i = 8'h00;
    @(negedge clk);
    chk("t4_ovf_first", 32'(overflow), 0);
    tick(); req_i = 8'h10;
    tick(); req_i = 8'h00;
    @(negedge clk);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_pending", 32'(pending), 32'h10);
    chk("t4_hold_idx", 32'(out_idx), 2);
    chk("t4_hold_onehot", 32'(out_onehot), 32'h04);
    clr_ovf = 1'b1;
    tick(); clr_ovf = 1'b0;
    @(negedge clk);
    chk("t4_ovf_cleared", 32'(overflow), 0);
    tick(); out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t4_idle", 32'(out_valid), 0);
    chk("t4_pending_end", 32'(pending), 0);

    // Test 5: overflow set wins over clr_ovf in the same cycle
    tick();
    expect_grant(3'd0); expect_grant(3'd5);
    out_ready = 1'b0; req_i = 8'h01;
    tick(); req_i = 8'h00;
    tick(); req_i = 8'h20;
    tick(); req_i = 8'h00;
    @(negedge clk);
    chk("t5_pending", 32'(pending), 32'h20);
    tick(); req_i = 8'h20; clr_ovf = 1'b1;
    tick(); req_i = 8'h00; clr_ovf = 1'b0;
    @(negedge clk);
    chk("t5_set_wins", 32'(overflow), 1);
    tick(); clr_ovf = 1'b1;
    tick(); clr_ovf = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t5_ovf_cleared", 32'(overflow), 0);
    chk("t5_idle", 32'(out_valid), 0);

    // Test 6: asynchronous reset while holding a grant with pending work
    tick();
    out_ready = 1'b0; req_i = 8'h02;
    tick(); req_i = 8'h00;
    tick(); req_i = 8'h80;
    tick(); req_i = 8'h80;
    tick(); req_i = 8'h00;
    @(negedge clk);
    chk("t6_pre_valid", 32'(out_valid), 1);
    chk("t6_pre_pending", 32'(pending), 32'h80);
    chk("t6_pre_overflow", 32'(overflow), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 0);
    chk("t6_async_pending", 32'(pending), 0);
    chk("t6_async_overflow", 32'(overflow), 0);
    chk("t6_async_onehot", 32'(out_onehot), 0);
    tick(); tick(); rst_n = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t6_post_valid", 32'(out_valid), 0);
    chk("t6_post_pending", 32'(pending), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_encoder_8_to_3.md
Name: rr_encoder_8_to_3

Overview:
Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 one-hot decoder. Collects single-cycle request pulses on N lines into a pending register. Arbitrates among pending lines round-robin and presents one binary index at a time on a valid/ready output. Sits between event sources (interrupt/strobe lines) and a consumer that re-expands the index with the decoder.

Parameters:
N, 8, number of request lines; must be a power of 2, at least 2.
W, 3, index width; equals clog2(N).

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_i  input  N  request pulses; bit k high in a cycle means one event on line k.
out_ready  input  1  consumer accepts the output when high together with out_valid.
clr_ovf  input  1  synchronous clear of the overflow flag.
out_valid  output  1  out_idx/out_onehot hold a granted request.
out_idx  output  W  binary index of the granted line.
out_onehot  output  N  one-hot of out_idx; all zeros when out_valid=0.
pending  output  N  registered pending vector; visible for debug and status.
overflow  output  1  sticky flag: at least one request was merged into an already-pending bit.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): out_valid=0, out_idx=0, out_onehot=0, pending=0, overflow=0, round-robin pointer ptr=0. Reset mid-handshake discards the held output and all pending requests.
- Pending update, every edge: pending_next = (pending & ~clear_mask) | req_i.
  - clear_mask is the one-hot of the line loaded into the output this edge, or 0 if nothing is loaded.
- Output register, two states:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
  - Output is "free" when in IDLE, or in HOLD with out_ready=1 (a transfer completes).
  - When free and pending≠0: select line s, load out_idx=s and out_onehot=1<<s, clear pending[s], set ptr=(s+1) mod N, and go to or stay in HOLD.
  - When free and pending=0: go to IDLE; out_onehot=0; out_idx keeps its last value.
  - In HOLD with out_ready=0: out_idx and out_onehot stay stable, ptr stays unchanged, no selection happens.
- Selection: s is the first set bit of pending, searching upward from ptr and wrapping past N-1 to 0. Selection uses registered pending only; req_i arriving this cycle is not eligible.
- Latency: a req_i pulse sampled at edge k sets pending at edge k. With the output free, out_valid=1 with that index after edge k+1 (two-edge latency). Back-to-back throughput is one grant per cycle while out_ready=1.
- Overflow:
  - Set at an edge when req_i[j]=1, pending[j]=1, and j is not being cleared that edge. The request is merged and the event is lost.
  - req_i[j] in the same cycle that line j is loaded re-arms pending[j]; no overflow.
  - clr_ovf=1 clears overflow. If a new overflow condition occurs in the same cycle, overflow is 1 (set wins).
- Multiple simultaneous req_i bits are all captured; each line produces exactly one grant per pending set.

Optional Feature:
Macro RR_ENCODER_FIXED_PRIORITY_EN.
- Defined: selection ignores ptr; the lowest set pending bit always wins (plain priority encoder). ptr is not implemented.
- Undefined (default): round-robin as above.
- Test 3 expectations change accordingly when the macro is defined (idx0 is granted before idx1).

Test Plan:
1. Reset with req_i=0xFF held and rst_n low -> all outputs 0. Release rst_n with req_i=0 -> outputs remain 0; pending stays 0x00.
2. One-cycle req_i=0x09, out_ready=1 -> out_valid with out_idx=0, out_onehot=0x01; next cycle out_idx=3, out_onehot=0x08; then out_valid=0, pending=0x00, overflow=0.
3. req_i=0x03, out_ready=0 -> HOLD with idx0 stable. Pulse req_i=0x01 again (pending→0x03, overflow=0). Raise out_ready -> grants idx1 then idx0 (ptr=1 after the first grant).
4. req_i=0x04 with out_ready=0 -> idx2 held. Pulse req_i=0x10 twice -> overflow=1 after the second pulse, pending=0x10. Pulse clr_ovf -> overflow=0. Raise out_ready -> idx4 granted once.
5. Assert clr_ovf in the same cycle as a duplicate req_i[5] on pending[5]=1 -> overflow=1.
6. With out_valid=1 and pending=0x80, drop rst_n mid-cycle -> out_valid, pending, and overflow go to 0 immediately, without waiting for a clock edge.
